// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: retires one instruction per handshake into the register file,
// commits CP0 reads/writes, raises exception/eret flush pulses, and drives forwarding and trace.
module wb_commit_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned CP0_AW     = 8,
    parameter int unsigned CP0_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [XLEN-1:0]   ms_pc,
    input  logic [XLEN-1:0]   ms_result,
    input  logic [XLEN-1:0]   ms_rt_value,
    input  logic [XLEN-1:0]   ms_badvaddr,
    input  logic              ms_gr_we,
    input  logic              ms_res_from_cp0,
    input  logic              ms_mtc0_we,
    input  logic              ms_ex,
    input  logic              ms_bd,
    input  logic              ms_eret,
    input  logic [REG_AW-1:0] ms_dest,
    input  logic [CP0_AW-1:0] ms_cp0_addr,
    input  logic [4:0]        ms_excode,
    output logic [CP0_AW-1:0] cp0_addr,
    output logic              cp0_rd_req,
    input  logic [XLEN-1:0]   cp0_rdata,
    output logic              cp0_we,
    output logic [XLEN-1:0]   cp0_wdata,
    output logic              wb_ex,
    output logic [4:0]        wb_excode,
    output logic [XLEN-1:0]   wb_badvaddr,
    output logic [XLEN-1:0]   wb_pc,
    output logic              wb_bd,
    output logic              eret_flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic              fwd_blocking,
    output logic [REG_AW-1:0] fwd_dest,
    output logic [XLEN-1:0]   fwd_data,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(CP0_RD_LAT);

    logic              ws_valid;
    logic [CNT_W-1:0]  cnt;

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   result_q;
    logic [XLEN-1:0]   rt_value_q;
    logic [XLEN-1:0]   badvaddr_q;
    logic              gr_we_q;
    logic              res_from_cp0_q;
    logic              mtc0_we_q;
    logic              ex_q;
    logic              bd_q;
    logic              eret_q;
    logic [REG_AW-1:0] dest_q;
    logic [CP0_AW-1:0] cp0_addr_q;
    logic [4:0]        excode_q;

    logic ready_go;
    logic commit_ok;
    logic flush;
    logic accept;
    logic dest_nz;

    assign ready_go   = !(ws_valid && res_from_cp0_q && !ex_q && (cnt != '0));
    assign ws_allowin = !ws_valid || ready_go;
    assign commit_ok  = ws_valid && ready_go && !ex_q && !eret_q;
    assign flush      = wb_ex || eret_flush;
    assign accept     = ms_to_ws_valid && ws_allowin && !flush;
    assign dest_nz    = (dest_q != '0);

    // Valid bit and mfc0 wait counter; a flush wins over any offered transfer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            cnt      <= '0;
        end else if (flush) begin
            ws_valid <= 1'b0;
            cnt      <= '0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
            cnt      <= (ms_to_ws_valid && ms_res_from_cp0 && !ms_ex) ? LAT : '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q           <= '0;
            result_q       <= '0;
            rt_value_q     <= '0;
            badvaddr_q     <= '0;
            gr_we_q        <= 1'b0;
            res_from_cp0_q <= 1'b0;
            mtc0_we_q      <= 1'b0;
            ex_q           <= 1'b0;
            bd_q           <= 1'b0;
            eret_q         <= 1'b0;
            dest_q         <= '0;
            cp0_addr_q     <= '0;
            excode_q       <= '0;
        end else if (accept) begin
            pc_q           <= ms_pc;
            result_q       <= ms_result;
            rt_value_q     <= ms_rt_value;
            badvaddr_q     <= ms_badvaddr;
            gr_we_q        <= ms_gr_we;
            res_from_cp0_q <= ms_res_from_cp0;
            mtc0_we_q      <= ms_mtc0_we;
            ex_q           <= ms_ex;
            bd_q           <= ms_bd;
            eret_q         <= ms_eret;
            dest_q         <= ms_dest;
            cp0_addr_q     <= ms_cp0_addr;
            excode_q       <= ms_excode;
        end
    end

    // CP0 side
    assign cp0_addr   = cp0_addr_q;
    assign cp0_rd_req = ws_valid && res_from_cp0_q && !ex_q;
    assign cp0_we     = commit_ok && mtc0_we_q;
    assign cp0_wdata  = rt_value_q;

    // Exception / eret; exception takes priority
    assign wb_ex       = ws_valid && ex_q;
    assign wb_excode   = excode_q;
    assign wb_badvaddr = badvaddr_q;
    assign wb_pc       = pc_q;
    assign wb_bd       = bd_q;
    assign eret_flush  = ws_valid && eret_q && !ex_q;

    // Register file write; r0 is never written
    assign rf_wdata = res_from_cp0_q ? cp0_rdata : result_q;
    assign rf_we    = commit_ok && gr_we_q && dest_nz;
    assign rf_waddr = dest_q;

    assign fwd_valid    = ws_valid && gr_we_q && !ex_q && !eret_q && dest_nz;
    assign fwd_blocking = fwd_valid && res_from_cp0_q && (cnt != '0);
    assign fwd_dest     = dest_q;
    assign fwd_data     = rf_wdata;

    assign debug_wb_pc       = 32'(pc_q);
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = 5'(dest_q);
    assign debug_wb_rf_wdata = 32'(rf_wdata);

endmodule

// File: tb/tb_wb_commit_stage.sv
// Randomised scoreboard bench for wb_commit_stage: expected commits are queued at acceptance
// and popped by a monitor whenever the stage raises a commit strobe.
module tb_wb_commit_stage;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc, ms_result, ms_rt_value, ms_badvaddr;
    logic        ms_gr_we, ms_res_from_cp0, ms_mtc0_we, ms_ex, ms_bd, ms_eret;
    logic [4:0]  ms_dest;
    logic [7:0]  ms_cp0_addr;
    logic [4:0]  ms_excode;
    logic [7:0]  cp0_addr;
    logic        cp0_rd_req;
    logic [31:0] cp0_rdata;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic [31:0] wb_badvaddr, wb_pc;
    logic        wb_bd, eret_flush, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid, fwd_blocking;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    always #5 clk = ~clk;

    wb_commit_stage #(.XLEN(32), .REG_AW(5), .CP0_AW(8), .CP0_RD_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_rt_value(ms_rt_value), .ms_badvaddr(ms_badvaddr),
        .ms_gr_we(ms_gr_we), .ms_res_from_cp0(ms_res_from_cp0), .ms_mtc0_we(ms_mtc0_we),
        .ms_ex(ms_ex), .ms_bd(ms_bd), .ms_eret(ms_eret),
        .ms_dest(ms_dest), .ms_cp0_addr(ms_cp0_addr), .ms_excode(ms_excode),
        .cp0_addr(cp0_addr), .cp0_rd_req(cp0_rd_req), .cp0_rdata(cp0_rdata),
        .cp0_we(cp0_we), .cp0_wdata(cp0_wdata),
        .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_badvaddr(wb_badvaddr), .wb_pc(wb_pc),
        .wb_bd(wb_bd), .eret_flush(eret_flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_blocking(fwd_blocking), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct {
        logic [31:0] pc, result, rt, bva, rdata;
        logic        gr_we, rfc0, mtc0, ex, bd, eret;
        logic [4:0]  dest, excode;
        logic [7:0]  caddr;
    } instr_t;

    typedef struct {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        cp0_we;
        logic [7:0]  caddr;
        logic [31:0] cwdata;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] bva;
        logic        bd;
        logic [31:0] pc;
        logic        eret;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;

    // Reference model state: the resident instruction and the cycle it commits in
    bit     res_v = 1'b0;
    instr_t res;
    int     res_commit = 0;
    int     cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Architectural outcome of committing one instruction
    function automatic bit make_exp(input instr_t i, output exp_t e);
        e = '{default: '0};
        e.pc = i.pc;
        if (i.ex) begin
            e.ex = 1'b1; e.excode = i.excode; e.bva = i.bva; e.bd = i.bd;
        end else if (i.eret) begin
            e.eret = 1'b1;
        end else begin
            e.rf_we  = i.gr_we && (i.dest != 5'd0);
            e.waddr  = i.dest;
            e.wdata  = i.rfc0 ? i.rdata : i.result;
            e.cp0_we = i.mtc0;
            e.caddr  = i.caddr;
            e.cwdata = i.rt;
        end
        return e.rf_we || e.cp0_we || e.ex || e.eret;
    endfunction

    function automatic instr_t blank();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int k;
        i = blank();
        k = $urandom_range(0, 9);
        i.pc = $urandom; i.result = $urandom; i.rt = $urandom; i.bva = $urandom; i.rdata = $urandom;
        i.dest = 5'($urandom); i.excode = 5'($urandom); i.caddr = 8'($urandom); i.bd = 1'($urandom);
        if (k <= 3) i.gr_we = 1'b1;
        else if (k <= 5) begin i.gr_we = 1'b1; i.rfc0 = 1'b1; end
        else if (k == 6) i.mtc0 = 1'b1;
        else if (k == 7) begin
            i.ex = 1'b1; i.gr_we = 1'($urandom); i.rfc0 = 1'($urandom); i.eret = 1'($urandom);
        end else if (k == 8) i.eret = 1'b1;
        return i;
    endfunction

    // Monitor: every commit strobe consumes one expected record
    exp_t m_e;
    always @(negedge clk) begin
        if (resetn === 1'b1 && (rf_we || cp0_we || wb_ex || eret_flush)) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_commit: got rf_we=%b cp0_we=%b wb_ex=%b eret_flush=%b want none (cycle %0d)",
                         rf_we, cp0_we, wb_ex, eret_flush, cyc);
            end else begin
                m_e = sb.pop_front();
                chk("rf_we", 32'(rf_we), 32'(m_e.rf_we));
                chk("trace_wen", 32'(debug_wb_rf_wen), 32'({4{m_e.rf_we}}));
                if (m_e.rf_we) begin
                    chk("rf_waddr", 32'(rf_waddr), 32'(m_e.waddr));
                    chk("rf_wdata", rf_wdata, m_e.wdata);
                    chk("trace_wnum", 32'(debug_wb_rf_wnum), 32'(m_e.waddr));
                    chk("trace_wdata", debug_wb_rf_wdata, m_e.wdata);
                end
                chk("cp0_we", 32'(cp0_we), 32'(m_e.cp0_we));
                if (m_e.cp0_we) begin
                    chk("cp0_addr_w", 32'(cp0_addr), 32'(m_e.caddr));
                    chk("cp0_wdata", cp0_wdata, m_e.cwdata);
                end
                chk("wb_ex", 32'(wb_ex), 32'(m_e.ex));
                if (m_e.ex) begin
                    chk("wb_excode", 32'(wb_excode), 32'(m_e.excode));
                    chk("wb_badvaddr", wb_badvaddr, m_e.bva);
                    chk("wb_bd", 32'(wb_bd), 32'(m_e.bd));
                    chk("wb_pc", wb_pc, m_e.pc);
                end
                chk("eret_flush", 32'(eret_flush), 32'(m_e.eret));
                chk("trace_pc", debug_wb_pc, m_e.pc);
            end
        end
    end

    // One cycle: drive at posedge+1, check stall/forward state at negedge, advance model
    task automatic step(input bit v, input instr_t in, output bit acc, output bit drop);
        bit exp_allow, fv, fb, flush_now, leave;
        exp_t e;
        ms_to_ws_valid = v;
        ms_pc = in.pc; ms_result = in.result; ms_rt_value = in.rt; ms_badvaddr = in.bva;
        ms_gr_we = in.gr_we; ms_res_from_cp0 = in.rfc0; ms_mtc0_we = in.mtc0;
        ms_ex = in.ex; ms_bd = in.bd; ms_eret = in.eret;
        ms_dest = in.dest; ms_cp0_addr = in.caddr; ms_excode = in.excode;
        cp0_rdata = (res_v && res.rfc0 && !res.ex && cyc == res_commit) ? res.rdata : $urandom;
        @(negedge clk);
        exp_allow = !res_v || (cyc == res_commit);
        chk("ws_allowin", 32'(ws_allowin), 32'(exp_allow));
        fv = res_v && res.gr_we && !res.ex && !res.eret && (res.dest != 5'd0);
        fb = fv && res.rfc0 && (cyc != res_commit);
        chk("fwd_valid", 32'(fwd_valid), 32'(fv));
        chk("fwd_blocking", 32'(fwd_blocking), 32'(fb));
        if (fv) chk("fwd_dest", 32'(fwd_dest), 32'(res.dest));
        chk("cp0_rd_req", 32'(cp0_rd_req), 32'(res_v && res.rfc0 && !res.ex));
        if (res_v) chk("cp0_addr", 32'(cp0_addr), 32'(res.caddr));
        flush_now = res_v && (cyc == res_commit) && (res.ex || res.eret);
        leave     = res_v && (cyc == res_commit);
        acc  = v && exp_allow && !flush_now;
        drop = v && flush_now;
        @(posedge clk);
        #1;
        cyc++;
        if (leave) res_v = 1'b0;
        if (acc) begin
            res_v = 1'b1;
            res = in;
            res_commit = cyc + ((in.rfc0 && !in.ex) ? int'(LAT) : 0);
            if (make_exp(in, e)) sb.push_back(e);
        end
    endtask

    // Hold an offer until accepted or dropped by a flush
    task automatic offer(input instr_t in, output bit acc);
        bit drop;
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, in, acc, drop);
            if (acc || drop) return;
        end
        total++; bad++;
        $display("FAIL offer_timeout: got no acceptance want acceptance within 20 cycles");
    endtask

    task automatic idle(input int n);
        bit a, d;
        for (int k = 0; k < n; k++) step(1'b0, blank(), a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t i;
        exp_t   tmp;
        bit     acc;

        resetn = 1'b0;
        ms_to_ws_valid = 1'b0;
        i = blank();
        ms_pc = '0; ms_result = '0; ms_rt_value = '0; ms_badvaddr = '0;
        ms_gr_we = 0; ms_res_from_cp0 = 0; ms_mtc0_we = 0; ms_ex = 0; ms_bd = 0; ms_eret = 0;
        ms_dest = '0; ms_cp0_addr = '0; ms_excode = '0; cp0_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_allowin", 32'(ws_allowin), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_cp0_we", 32'(cp0_we), 32'd0);
        chk("rst_cp0_rd_req", 32'(cp0_rd_req), 32'd0);
        chk("rst_wb_ex", 32'(wb_ex), 32'd0);
        chk("rst_eret_flush", 32'(eret_flush), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_fwd_blocking", 32'(fwd_blocking), 32'd0);
        chk("rst_trace_wen", 32'(debug_wb_rf_wen), 32'd0);
        chk("rst_trace_pc", debug_wb_pc, 32'd0);
        @(posedge clk);
        #1;

        // ALU op
        i = blank(); i.pc = 32'hBFC00000; i.dest = 5'd3; i.result = 32'h12345678; i.gr_we = 1'b1;
        offer(i, acc);
        idle(1);

        // mfc0 with multi-cycle read
        i = blank(); i.pc = 32'hBFC00004; i.dest = 5'd5; i.caddr = 8'h60; i.gr_we = 1'b1;
        i.rfc0 = 1'b1; i.rdata = 32'hDEAD0001;
        offer(i, acc);
        idle(LAT + 1);

        // Exception with the next op offered straight behind it
        i = blank(); i.pc = 32'hBFC00008; i.ex = 1'b1; i.excode = 5'h04; i.bva = 32'h80000003;
        i.gr_we = 1'b1; i.dest = 5'd7;
        offer(i, acc);
        i = blank(); i.pc = 32'hBFC0000C; i.gr_we = 1'b1; i.dest = 5'd8; i.result = 32'h0BAD0BAD;
        offer(i, acc);
        idle(2);

        // ex+eret, then eret alone
        i = blank(); i.pc = 32'hBFC00010; i.ex = 1'b1; i.eret = 1'b1; i.excode = 5'h08; i.bd = 1'b1;
        offer(i, acc);
        idle(1);
        i = blank(); i.pc = 32'hBFC00014; i.eret = 1'b1;
        offer(i, acc);
        idle(1);

        // mtc0, then ALU write to r0
        i = blank(); i.pc = 32'hBFC00018; i.mtc0 = 1'b1; i.rt = 32'h0000FF01; i.caddr = 8'h60;
        offer(i, acc);
        i = blank(); i.pc = 32'hBFC0001C; i.gr_we = 1'b1; i.dest = 5'd0; i.result = 32'h55555555;
        offer(i, acc);
        idle(2);

        // Reset in the middle of an mfc0 wait aborts it
        i = blank(); i.pc = 32'hBFC00020; i.dest = 5'd9; i.caddr = 8'h61; i.gr_we = 1'b1;
        i.rfc0 = 1'b1; i.rdata = 32'hCAFE0009;
        offer(i, acc);
        resetn = 1'b0;
        ms_to_ws_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc++;
        res_v = 1'b0;
        if (acc && sb.size() > 0) tmp = sb.pop_back();
        @(negedge clk);
        chk("abort_allowin", 32'(ws_allowin), 32'd1);
        chk("abort_fwd_blocking", 32'(fwd_blocking), 32'd0);
        chk("abort_cp0_rd_req", 32'(cp0_rd_req), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        idle(LAT + 2);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            i = rand_instr();
            offer(i, acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(LAT + 3);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
